// File: rtl/joystick_input.sv
// rtl/joystick_input.sv - button synchroniser, debouncer and frame-locked direction request
//
// Purpose:
//   Conditions the four board buttons for the drawing logic. Each raw button
//   passes through a two-flop synchroniser and then a debouncer that has its
//   own counter. The debounced levels produce one-cycle press pulses. A press
//   is held as a pending direction request, and that request is committed to
//   `dir` only on the frame strobe, so the direction never changes mid-frame.
//
// Optional feature:
//   JOYSTICK_DEBOUNCE_BYPASS_EN - when defined, the debounce counters are
//   removed and the stable state follows the synchroniser every cycle
//   (simulation builds only). Leave it undefined for synthesis.
//
// Ports:
//   vga_pix_clk  in   1  pixel clock; all logic on its rising edge
//   CPU_RESETN   in   1  synchronous active-low reset
//   BTNU/D/L/R   in   1  raw buttons, asynchronous to vga_pix_clk
//   frame_stb    in   1  one-cycle start-of-frame strobe
//   btn_level    out  4  debounced levels {U,D,L,R}
//   btn_press    out  4  one-cycle rising-edge pulses, same order
//   dir          out  2  committed direction 0=RIGHT 1=UP 2=LEFT 3=DOWN
//   dir_valid    out  1  set once any direction has been committed
//   dir_changed  out  1  one-cycle pulse after a commit that changed dir

module joystick_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       vga_pix_clk,
  input  logic       CPU_RESETN,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       frame_stb,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       dir_changed
);

  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_stable;
  logic [3:0] r_level_q;
  logic [3:0] w_press;
  logic [1:0] r_pend_dir;
  logic       r_pend_valid;
  logic [1:0] r_dir;
  logic       r_dir_valid;
  logic       r_dir_changed;
  logic       w_any_press;
  logic       w_commit;
  logic [1:0] w_press_dir;
  logic [1:0] w_new_dir;

  assign w_raw = {BTNU, BTND, BTNL, BTNR};

  // Priority U > D > L > R when several presses land in the same cycle.
  function automatic logic [1:0] enc_dir(input logic [3:0] p);
    if (p[3])      enc_dir = 2'd1;
    else if (p[2]) enc_dir = 2'd3;
    else if (p[1]) enc_dir = 2'd2;
    else           enc_dir = 2'd0;
  endfunction

  always_ff @(posedge vga_pix_clk) begin
    if (!CPU_RESETN) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level_q <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_stable;
    end
  end

`ifdef JOYSTICK_DEBOUNCE_BYPASS_EN
  always_ff @(posedge vga_pix_clk) begin
    if (!CPU_RESETN) r_stable <= '0;
    else             r_stable <= r_sync2;
  end
`else
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [4];

  // The counter only advances while the synchronised input disagrees with
  // the stable state. Any cycle of agreement restarts it, so only an
  // unbroken run of DEBOUNCE_CYCLES mismatching cycles flips the state.
  always_ff @(posedge vga_pix_clk) begin
    if (!CPU_RESETN) begin
      r_stable <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  assign w_press     = r_stable & ~r_level_q;
  assign w_any_press = |w_press;
  assign w_press_dir = enc_dir(w_press);
  // A press in the strobe cycle is newer than anything pending, so it wins.
  assign w_new_dir   = w_any_press ? w_press_dir : r_pend_dir;
  assign w_commit    = frame_stb & (w_any_press | r_pend_valid);

  always_ff @(posedge vga_pix_clk) begin
    if (!CPU_RESETN) begin
      r_pend_dir    <= 2'd0;
      r_pend_valid  <= 1'b0;
      r_dir         <= 2'd0;
      r_dir_valid   <= 1'b0;
      r_dir_changed <= 1'b0;
    end else begin
      r_dir_changed <= 1'b0;
      if (w_commit) begin
        r_dir         <= w_new_dir;
        r_dir_valid   <= 1'b1;
        r_pend_valid  <= 1'b0;
        r_dir_changed <= (w_new_dir != r_dir);
      end else if (w_any_press) begin
        r_pend_dir   <= w_press_dir;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign btn_level   = r_stable;
  assign btn_press   = w_press;
  assign dir         = r_dir;
  assign dir_valid   = r_dir_valid;
  assign dir_changed = r_dir_changed;

endmodule

// File: tb/tb_joystick_input.sv
// tb/tb_joystick_input.sv - directed self-checking bench for joystick_input (DEBOUNCE_CYCLES=4)

module tb_joystick_input;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btnu, btnd, btnl, btnr;
  logic       frame_stb;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_changed;

  int checks = 0;
  int failures = 0;

  joystick_input #(.DEBOUNCE_CYCLES(4)) dut (
    .vga_pix_clk (clk),
    .CPU_RESETN  (resetn),
    .BTNU        (btnu),
    .BTND        (btnd),
    .BTNL        (btnl),
    .BTNR        (btnr),
    .frame_stb   (frame_stb),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .dir         (dir),
    .dir_valid   (dir_valid),
    .dir_changed (dir_changed)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; values are then read 1 time unit after the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {btnu, btnd, btnl, btnr} = 4'b0000;
    frame_stb = 1'b0;
    tick(3);
    resetn = 1'b1;
  endtask

  task automatic strobe();
    frame_stb = 1'b1;
    tick(1);
    frame_stb = 1'b0;
  endtask

`ifdef JOYSTICK_DEBOUNCE_BYPASS_EN
  // Bypass: level follows sync output, visible at the 3rd edge counting the sampling edge.
  task automatic test_bypass();
    do_reset();
    btnd = 1'b1;
    tick(1);
    btnd = 1'b0;
    for (int n = 2; n <= 6; n++) begin
      tick(1);
      checks++;
      if (btn_level[2] !== (n == 3)) begin
        failures++;
        $display("FAIL bypass_level edge=%0d got=%b want=%b", n, btn_level[2], (n == 3));
      end
      checks++;
      if (btn_press[2] !== (n == 3)) begin
        failures++;
        $display("FAIL bypass_press edge=%0d got=%b want=%b", n, btn_press[2], (n == 3));
      end
    end
  endtask
`else
  task automatic test_reset();
    resetn = 1'b0;
    {btnu, btnd, btnl, btnr} = 4'b1000;
    frame_stb = 1'b0;
    tick(3);
    checks++;
    if ({btn_level, btn_press, dir, dir_valid, dir_changed} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000", {btn_level, btn_press, dir, dir_valid, dir_changed});
    end
    resetn = 1'b1;
    // Edge 1 is the first sampling edge; level must rise at edge 6.
    for (int n = 1; n <= 9; n++) begin
      tick(1);
      checks++;
      if (btn_level[3] !== (n >= 6)) begin
        failures++;
        $display("FAIL reset_level_u edge=%0d got=%b want=%b", n, btn_level[3], (n >= 6));
      end
      checks++;
      if (btn_press !== ((n == 6) ? 4'b1000 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_press_u edge=%0d got=%b", n, btn_press);
      end
    end
    btnu = 1'b0;
    tick(8);
  endtask

  task automatic test_glitch();
    do_reset();
    btnl = 1'b1;
    tick(3);
    btnl = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      checks++;
      if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
        failures++;
        $display("FAIL glitch_level n=%0d level=%b press=%b want=0000", n, btn_level, btn_press);
      end
    end
    strobe();
    checks++;
    if (dir_valid !== 1'b0 || dir !== 2'd0) begin
      failures++;
      $display("FAIL glitch_no_pend dir_valid=%b dir=%0d want 0/0", dir_valid, dir);
    end
  endtask

  task automatic test_priority();
    do_reset();
    btnu = 1'b1;
    btnr = 1'b1;
    tick(20);
    checks++;
    if (dir !== 2'd0 || dir_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_frozen dir=%0d dir_valid=%b want 0/0", dir, dir_valid);
    end
    strobe();
    checks++;
    if (dir !== 2'd1 || dir_valid !== 1'b1 || dir_changed !== 1'b1) begin
      failures++;
      $display("FAIL prio_commit dir=%0d valid=%b chg=%b want 1/1/1", dir, dir_valid, dir_changed);
    end
    tick(1);
    checks++;
    if (dir_changed !== 1'b0) begin
      failures++;
      $display("FAIL prio_chg_pulse got=%b want=0", dir_changed);
    end
    btnu = 1'b0;
    btnr = 1'b0;
    tick(8);
  endtask

  task automatic test_last_press();
    do_reset();
    btnl = 1'b1; tick(8);
    btnl = 1'b0; tick(8);
    btnd = 1'b1; tick(8);
    btnd = 1'b0; tick(8);
    strobe();
    checks++;
    if (dir !== 2'd3 || dir_valid !== 1'b1 || dir_changed !== 1'b1) begin
      failures++;
      $display("FAIL last_commit dir=%0d valid=%b chg=%b want 3/1/1", dir, dir_valid, dir_changed);
    end
    tick(4);
    strobe();
    checks++;
    if (dir !== 2'd3 || dir_changed !== 1'b0) begin
      failures++;
      $display("FAIL last_second_stb dir=%0d chg=%b want 3/0", dir, dir_changed);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    btnu = 1'b1; tick(8);
    btnu = 1'b0; tick(8);
    strobe();
    checks++;
    if (dir !== 2'd1) begin
      failures++;
      $display("FAIL same_setup dir=%0d want=1", dir);
    end
    // Pend DOWN, then an R press lands exactly on the strobe.
    btnd = 1'b1; tick(8);
    btnd = 1'b0; tick(8);
    btnr = 1'b1;
    tick(6);
    checks++;
    if (btn_press !== 4'b0001) begin
      failures++;
      $display("FAIL same_press_align got=%b want=0001", btn_press);
    end
    strobe();
    checks++;
    if (dir !== 2'd0 || dir_changed !== 1'b1 || dir_valid !== 1'b1) begin
      failures++;
      $display("FAIL same_commit dir=%0d chg=%b valid=%b want 0/1/1", dir, dir_changed, dir_valid);
    end
    tick(4);
    strobe();
    checks++;
    if (dir !== 2'd0 || dir_changed !== 1'b0) begin
      failures++;
      $display("FAIL same_pend_cleared dir=%0d chg=%b want 0/0", dir, dir_changed);
    end
    btnr = 1'b0;
    tick(8);
  endtask

  task automatic test_reset_mid_pending();
    do_reset();
    btnl = 1'b1; tick(8);
    btnl = 1'b0; tick(2);
    do_reset();
    strobe();
    checks++;
    if (dir_valid !== 1'b0 || dir !== 2'd0) begin
      failures++;
      $display("FAIL reset_pend_discard valid=%b dir=%0d want 0/0", dir_valid, dir);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    {btnu, btnd, btnl, btnr} = 4'b0000;
    frame_stb = 1'b0;
`ifdef JOYSTICK_DEBOUNCE_BYPASS_EN
    test_bypass();
`else
    test_reset();
    test_glitch();
    test_priority();
    test_last_press();
    test_same_cycle();
    test_reset_mid_pending();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
